// File: rtl/iod_ref_clk_train_ctrl_pkg.sv
// Purpose : shared types and constants for the IOD reference-clock training controller.
// Latency : n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state codes, tap/word types, delay-line direction codes, window helpers.
package iod_train_pkg;

   // FSM state codes, kept as plain constants so older code can match on the raw values.
   typedef logic [3:0] state_t;
   localparam state_t ST_IDLE   = 4'd0;
   localparam state_t ST_LOAD   = 4'd1;
   localparam state_t ST_CLEAR  = 4'd2;
   localparam state_t ST_SETTLE = 4'd3;
   localparam state_t ST_SAMPLE = 4'd4;
   localparam state_t ST_EVAL   = 4'd5;
   localparam state_t ST_STEP   = 4'd6;
   localparam state_t ST_FINISH = 4'd7;
   localparam state_t ST_RETURN = 4'd8;
   localparam state_t ST_DONE   = 4'd9;
   localparam state_t ST_FAIL   = 4'd10;

   // Tap index relative to the loaded static delay, and the deserialized word.
   typedef logic [7:0] tap_t;
   typedef logic [7:0] rx_word_t;

   // Delay line direction encoding.
   localparam logic DIR_INC = 1'b1;
   localparam logic DIR_DEC = 1'b0;

   // Run length counter that sticks at its maximum instead of wrapping.
   function automatic tap_t sat_inc(input tap_t v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Centre of a window, rounded toward the window start for even lengths.
   function automatic tap_t win_centre(input tap_t start, input tap_t len);
      return start + ((len - 8'd1) >> 1);
   endfunction

endpackage

// File: rtl/iod_ref_clk_train_ctrl_if.sv
// Purpose : bundles the IOD delay-line / eye-monitor pins between controller and IOD.
// Latency : n/a (wires only).
// Backpressure: none; all pulses are fire-and-forget, flags are levels.
// Ports   : master = training controller side, slave = IOD side.
interface iod_ref_clk_train_ctrl_if;
   import iod_train_pkg::*;

   rx_word_t rx_data;                  // deserialized reference-clock word
   logic     eye_monitor_early;        // sticky early flag
   logic     eye_monitor_late;         // sticky late flag
   logic     delay_line_out_of_range;  // delay line reached its limit
   logic     eye_monitor_clear_flags;  // one-cycle flag clear
   logic     delay_line_move;          // one-cycle step request
   logic     delay_line_direction;     // 1 = increment, 0 = decrement
   logic     delay_line_load;          // one-cycle reload of the static delay

   modport master (
      input  rx_data,
      input  eye_monitor_early,
      input  eye_monitor_late,
      input  delay_line_out_of_range,
      output eye_monitor_clear_flags,
      output delay_line_move,
      output delay_line_direction,
      output delay_line_load
   );

   modport slave (
      output rx_data,
      output eye_monitor_early,
      output eye_monitor_late,
      output delay_line_out_of_range,
      input  eye_monitor_clear_flags,
      input  delay_line_move,
      input  delay_line_direction,
      input  delay_line_load
   );

endinterface

// File: rtl/iod_ref_clk_train_ctrl_tap_qual.sv
// Purpose : qualifies one tap: settle wait, reference capture, word compare, eye flags.
// Latency : SETTLE_CYCLES cycles to settle_done, then SAMPLE_CYCLES cycles to qual_done.
// Backpressure: none; advances only while the matching enable is held by the FSM.
// Ports   : clr restarts the counter; settle_en/sample_en select the phase;
//           settle_done/qual_done mark the last cycle of each phase; stable is valid after qual_done.
module iod_train_tap_qual
   import iod_train_pkg::*;
#(
   parameter int SETTLE_CYCLES = 8,
   parameter int SAMPLE_CYCLES = 16
) (
   input  logic     fab_clk,
   input  logic     reset,
   input  logic     clr,
   input  logic     settle_en,
   input  logic     sample_en,
   input  rx_word_t rx_data,
   input  logic     eye_early,
   input  logic     eye_late,
   output logic     settle_done,
   output logic     qual_done,
   output logic     stable
);

   localparam int CNT_W = 16;

   logic [CNT_W-1:0] cnt;
   rx_word_t         ref_word;
   logic             mismatch;

   assign settle_done = settle_en && (cnt == CNT_W'(SETTLE_CYCLES - 1));
   assign qual_done   = sample_en && (cnt == CNT_W'(SAMPLE_CYCLES - 1));

   // Eye flags are sticky in the IOD since the last clear, so reading them
   // once at evaluation covers the whole settle + sample interval.
   assign stable = !mismatch && !eye_early && !eye_late;

   always_ff @(posedge fab_clk) begin
      if (reset) begin
         cnt      <= '0;
         ref_word <= '0;
         mismatch <= 1'b0;
      end else if (clr) begin
         cnt <= '0;
      end else if (settle_en) begin
         if (settle_done) begin
            // Word seen at the end of settling becomes the reference for this tap.
            cnt      <= '0;
            ref_word <= rx_data;
            mismatch <= 1'b0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end else if (sample_en) begin
         mismatch <= mismatch | (rx_data != ref_word);
         cnt      <= qual_done ? '0 : cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge fab_clk) begin
      assert (SETTLE_CYCLES >= 1 && SAMPLE_CYCLES >= 1)
         else $error("settle/sample cycle counts must be at least 1");
   end

endmodule

// File: rtl/iod_ref_clk_train_ctrl.sv
// Purpose : sweeps the IOD input delay, finds the longest stable window, parks at its centre.
// Latency : per tap 1 clear + SETTLE + SAMPLE + 1 eval + 3 step cycles; return 2 cycles per tap.
// Backpressure: none; train_start is ignored while train_busy is high.
// Ports   : fab_clk/reset (sync, active-high); train_start/busy/done/fail status;
//           tap_pos, win_start, win_len results; iod = delay-line and eye-monitor pins.
module iod_ref_clk_train_ctrl
   import iod_train_pkg::*;
#(
   parameter int NUM_TAPS      = 128,
   parameter int SETTLE_CYCLES = 8,
   parameter int SAMPLE_CYCLES = 16,
   parameter int MIN_WINDOW    = 4
) (
   input  logic fab_clk,
   input  logic reset,
   input  logic train_start,
   output logic train_busy,
   output logic train_done,
   output logic train_fail,
   output tap_t tap_pos,
   output tap_t win_start,
   output tap_t win_len,
   iod_ref_clk_train_ctrl_if.master iod
);

   localparam tap_t LAST_TAP = tap_t'(NUM_TAPS - 1);
   localparam tap_t MIN_LEN  = tap_t'(MIN_WINDOW);

   state_t     state;
   logic [1:0] ph;          // sub-cycle within LOAD / STEP / RETURN
   logic       dir;
   logic       run_open;
   tap_t       run_start;
   tap_t       run_len;
   tap_t       target;

   logic       start_ok;
   logic       settle_done;
   logic       qual_done;
   logic       stable;
   logic       tap_stable;
   tap_t       best_start;
   tap_t       best_len;

   assign train_busy = !(state == ST_IDLE || state == ST_DONE || state == ST_FAIL);
   assign start_ok   = train_start && !train_busy;

   // Every pulse state is followed by a quiet cycle, so LOAD, CLEAR and MOVE
   // can never overlap or abut.
   assign iod.delay_line_load         = (state == ST_LOAD) && (ph == 2'd0);
   assign iod.eye_monitor_clear_flags = (state == ST_CLEAR);
   assign iod.delay_line_move         = (state == ST_STEP || state == ST_RETURN) && (ph == 2'd1);
   // Direction is a register so it stays put on both sides of every MOVE.
   assign iod.delay_line_direction    = dir;

   // A tap at the delay-line limit never counts as stable.
   assign tap_stable = stable && !iod.delay_line_out_of_range;

   // Result of closing the open run: it only wins when strictly longer,
   // so the earliest of equal-length windows is kept.
   always_comb begin
      best_start = win_start;
      best_len   = win_len;
      if (run_open && (run_len > win_len)) begin
         best_start = run_start;
         best_len   = run_len;
      end
   end

   iod_train_tap_qual #(
      .SETTLE_CYCLES (SETTLE_CYCLES),
      .SAMPLE_CYCLES (SAMPLE_CYCLES)
   ) u_tap_qual (
      .fab_clk     (fab_clk),
      .reset       (reset),
      .clr         (state == ST_CLEAR),
      .settle_en   (state == ST_SETTLE),
      .sample_en   (state == ST_SAMPLE),
      .rx_data     (iod.rx_data),
      .eye_early   (iod.eye_monitor_early),
      .eye_late    (iod.eye_monitor_late),
      .settle_done (settle_done),
      .qual_done   (qual_done),
      .stable      (stable)
   );

   always_ff @(posedge fab_clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         ph         <= 2'd0;
         dir        <= 1'b0;
         train_done <= 1'b0;
         train_fail <= 1'b0;
         tap_pos    <= '0;
         win_start  <= '0;
         win_len    <= '0;
         run_open   <= 1'b0;
         run_start  <= '0;
         run_len    <= '0;
         target     <= '0;
      end else if (start_ok) begin
         state      <= ST_LOAD;
         ph         <= 2'd0;
         train_done <= 1'b0;
         train_fail <= 1'b0;
         tap_pos    <= '0;
         win_start  <= '0;
         win_len    <= '0;
         run_open   <= 1'b0;
         run_start  <= '0;
         run_len    <= '0;
      end else begin
         case (state)
            ST_LOAD: begin
               if (ph == 2'd0) begin
                  ph <= 2'd1;
               end else begin
                  ph    <= 2'd0;
                  state <= ST_CLEAR;
               end
            end

            ST_CLEAR: state <= ST_SETTLE;

            ST_SETTLE: if (settle_done) state <= ST_SAMPLE;

            ST_SAMPLE: if (qual_done) state <= ST_EVAL;

            ST_EVAL: begin
               if (tap_stable) begin
                  if (run_open) begin
                     run_len <= sat_inc(run_len);
                  end else begin
                     run_open  <= 1'b1;
                     run_start <= tap_pos;
                     run_len   <= 8'd1;
                  end
               end else begin
                  win_start <= best_start;
                  win_len   <= best_len;
                  run_open  <= 1'b0;
                  run_len   <= '0;
               end
               if (tap_pos == LAST_TAP || iod.delay_line_out_of_range) begin
                  state <= ST_FINISH;
               end else begin
                  state <= ST_STEP;
                  ph    <= 2'd0;
                  dir   <= DIR_INC;
               end
            end

            // ph 0: direction set-up, ph 1: MOVE, ph 2: direction hold.
            ST_STEP: begin
               if (ph == 2'd0) begin
                  ph <= 2'd1;
               end else if (ph == 2'd1) begin
                  tap_pos <= tap_pos + 8'd1;
                  ph      <= 2'd2;
               end else begin
                  ph    <= 2'd0;
                  state <= ST_CLEAR;
               end
            end

            ST_FINISH: begin
               win_start <= best_start;
               win_len   <= best_len;
               run_open  <= 1'b0;
               run_len   <= '0;
               if (best_len < MIN_LEN) begin
                  // Delay line intentionally left at the last swept tap.
                  train_fail <= 1'b1;
                  state      <= ST_FAIL;
               end else begin
                  target <= win_centre(best_start, best_len);
                  dir    <= DIR_DEC;
                  ph     <= 2'd0;
                  state  <= ST_RETURN;
               end
            end

            // ph 0: compare / direction hold, ph 1: decrement MOVE.
            ST_RETURN: begin
               if (ph == 2'd0) begin
                  if (tap_pos == target) begin
                     train_done <= 1'b1;
                     state      <= ST_DONE;
                  end else begin
                     ph <= 2'd1;
                  end
               end else begin
                  tap_pos <= tap_pos - 8'd1;
                  ph      <= 2'd0;
               end
            end

            ST_DONE: state <= ST_IDLE;
            ST_FAIL: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge fab_clk) begin
      assert (NUM_TAPS >= 1 && NUM_TAPS <= 256)
         else $error("NUM_TAPS must be in 1..256 for an 8-bit tap index");
   end

endmodule
